prv_trap_ctrl: RTL
==================

PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

Interface
REQ-001 SHALL have ports CLK (in, 1, clock) and nRST (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-002 SHALL have inputs fault_insn, mal_insn, illegal_insn, breakpoint, env, mal_l, mal_s, fault_l, fault_s (in, 1 each): synchronous exception flags from the hazard unit.
REQ-003 SHALL have inputs ret (in, 1, mret), wfi (in, 1), pipe_clear (in, 1, pipeline drained), epc (in, 32, faulting PC), badaddr (in, 32, fault address).
REQ-004 SHALL have inputs timer_int, soft_int, ext_int (in, 1 each, pending), mie_bits (in, 3, {ext,soft,timer} enables), mstatus_mie (in, 1), mtvec (in, 32), mepc_r (in, 32).
REQ-005 SHALL have outputs insert_pc (out, 1), priv_pc (out, 32), intr (out, 1), wfi_stall (out, 1).
REQ-006 SHALL have outputs mcause_we/mepc_we/mtval_we (out, 1 each), mcause_wdata/mepc_wdata/mtval_wdata (out, 32 each), mstatus_trap (out, 1, MIE->MPIE push), mstatus_ret (out, 1, MPIE->MIE pop).

Function
REQ-007 SHALL implement FSM states IDLE, WFI_WAIT, REDIRECT; reset state IDLE.
REQ-008 intr SHALL be combinational, high in IDLE when (pending & mie_bits) != 0 and mstatus_mie=1; low in other states.
REQ-009 Exception priority, high to low: fault_insn(1), mal_insn(0), illegal_insn(2), breakpoint(3), env(11), mal_l(4), mal_s(6), fault_l(5), fault_s(7).
REQ-010 Interrupt priority: ext(11) > soft(3) > timer(7); mcause_wdata[31]=1 for interrupts, 0 for exceptions.
REQ-011 In IDLE, any exception flag SHALL be captured at the clock edge regardless of pipe_clear -> REDIRECT; it wins over a simultaneous interrupt, ret or wfi.
REQ-012 In IDLE, an interrupt (REQ-008 condition) SHALL be captured only when pipe_clear=1 and no exception is present -> REDIRECT.
REQ-013 In IDLE, ret with no exception/accepted interrupt -> REDIRECT with target mepc_r; wfi with none of those -> WFI_WAIT.
REQ-014 REDIRECT SHALL last exactly one cycle: insert_pc=1, priv_pc=registered target; trap: mcause_we=mepc_we=mtval_we=mstatus_trap=1, mepc_wdata=registered epc; ret: mstatus_ret=1 only; next state IDLE.
REQ-015 Trap target SHALL be {mtvec[31:2],2'b00}; mtval_wdata=registered badaddr for mal_*/fault_* causes, 0 otherwise.
REQ-016 WFI_WAIT SHALL hold wfi_stall=1; leave to IDLE the cycle after (pending & mie_bits) != 0, independent of mstatus_mie; an exception flag in WFI_WAIT is ignored.
REQ-017 Total latency event-to-insert_pc SHALL be exactly one cycle; no input is sampled during REDIRECT.

Reset
REQ-018 nRST low SHALL asynchronously force IDLE and all registered outputs and captured cause/epc/badaddr/target to 0, including mid-REDIRECT (strobes drop immediately, no partial CSR write).
REQ-019 Reset value of every output SHALL be 0 (intr follows REQ-008 from the deasserted-reset cycle).

Configuration
REQ-020 With PRV_TRAP_VECTORED_EN defined and mtvec[1:0]==2'b01, interrupt target SHALL be {mtvec[31:2],2'b00} + 4*cause; exceptions still use base.
REQ-021 Without PRV_TRAP_VECTORED_EN, mtvec[1:0] SHALL be ignored and all traps use base.

Structure
REQ-022 Exception/interrupt code enums and the FSM state enum SHALL live in machine_mode_types_1_12_pkg.
REQ-023 Priority encoding (REQ-009/010) SHALL be a combinational sub-module prv_trap_prio_enc.

Verification
REQ-024 illegal_insn=1, epc=0x0000_0100, mtvec=0x0000_0200 -> next cycle insert_pc=1, priv_pc=0x200, mcause_wdata=2, mepc_wdata=0x100, mtval_wdata=0.
REQ-025 mal_l=1 and fault_s=1 same cycle, badaddr=0x1003 -> mcause_wdata=4, mtval_wdata=0x1003.
REQ-026 timer_int=1, mie_bits=3'b001, mstatus_mie=1, pipe_clear=0 for 3 cycles then 1 -> intr=1 throughout, insert_pc only one cycle after pipe_clear rises, mcause_wdata=0x8000_0007.
REQ-027 VECTORED_EN, mtvec=0x0000_0201, ext_int -> priv_pc=0x0000_022C; without macro -> priv_pc=0x0000_0200.
REQ-028 wfi=1, mstatus_mie=0, later soft_int=1 with mie_bits=3'b010 -> wfi_stall high until one cycle after soft_int, then IDLE, no trap taken.
REQ-029 ret=1, mepc_r=0x0000_0404 -> insert_pc=1, priv_pc=0x404, mstatus_ret=1, all CSR write strobes 0; nRST low in REDIRECT clears all outputs immediately.

Source files
------------

// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared trap types: FSM states, exception/interrupt cause codes and an mcause builder.
// Used by prv_trap_ctrl and prv_trap_prio_enc.
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WFI_WAIT = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  typedef enum logic [3:0] {
    EXC_INSN_MAL    = 4'd0,
    EXC_INSN_FAULT  = 4'd1,
    EXC_ILLEGAL     = 4'd2,
    EXC_BREAK       = 4'd3,
    EXC_LOAD_MAL    = 4'd4,
    EXC_LOAD_FAULT  = 4'd5,
    EXC_STORE_MAL   = 4'd6,
    EXC_STORE_FAULT = 4'd7,
    EXC_ECALL_M     = 4'd11
  } exc_code_t;

  typedef enum logic [3:0] {
    INT_SOFT  = 4'd3,
    INT_TIMER = 4'd7,
    INT_EXT   = 4'd11
  } int_code_t;

  function automatic logic [31:0] mk_cause(input logic is_int, input logic [3:0] code);
    return {is_int, 27'd0, code};
  endfunction

endpackage

// File: rtl/prv_trap_prio_enc.sv
// Combinational priority encoder for synchronous exceptions and enabled pending interrupts.
// o_exc_tval marks causes whose mtval carries the faulting address.
module prv_trap_prio_enc
  import machine_mode_types_1_12_pkg::*;
(
  input  logic       i_fault_insn,
  input  logic       i_mal_insn,
  input  logic       i_illegal_insn,
  input  logic       i_breakpoint,
  input  logic       i_env,
  input  logic       i_mal_l,
  input  logic       i_mal_s,
  input  logic       i_fault_l,
  input  logic       i_fault_s,
  input  logic [2:0] i_pend,
  output logic       o_exc_valid,
  output exc_code_t  o_exc_code,
  output logic       o_exc_tval,
  output logic       o_int_valid,
  output int_code_t  o_int_code
);

  always_comb begin
    o_exc_valid = 1'b1;
    o_exc_code  = EXC_INSN_FAULT;
    o_exc_tval  = 1'b0;
    if (i_fault_insn) begin
      o_exc_code = EXC_INSN_FAULT;
      o_exc_tval = 1'b1;
    end else if (i_mal_insn) begin
      o_exc_code = EXC_INSN_MAL;
      o_exc_tval = 1'b1;
    end else if (i_illegal_insn) begin
      o_exc_code = EXC_ILLEGAL;
    end else if (i_breakpoint) begin
      o_exc_code = EXC_BREAK;
    end else if (i_env) begin
      o_exc_code = EXC_ECALL_M;
    end else if (i_mal_l) begin
      o_exc_code = EXC_LOAD_MAL;
      o_exc_tval = 1'b1;
    end else if (i_mal_s) begin
      o_exc_code = EXC_STORE_MAL;
      o_exc_tval = 1'b1;
    end else if (i_fault_l) begin
      o_exc_code = EXC_LOAD_FAULT;
      o_exc_tval = 1'b1;
    end else if (i_fault_s) begin
      o_exc_code = EXC_STORE_FAULT;
      o_exc_tval = 1'b1;
    end else begin
      o_exc_valid = 1'b0;
    end
  end

  // i_pend is {ext, soft, timer}
  always_comb begin
    o_int_valid = |i_pend;
    o_int_code  = INT_TIMER;
    if (i_pend[2])      o_int_code = INT_EXT;
    else if (i_pend[1]) o_int_code = INT_SOFT;
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap/return controller: one-cycle redirect to trap vector or mepc, plus WFI stall.
// Optional PRV_TRAP_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==2'b01.
//
// state    | meaning
// IDLE     | normal run, sampling exceptions/interrupts/ret/wfi
// WFI_WAIT | stalled until an enabled interrupt is pending
// REDIRECT | one cycle: insert_pc and CSR update strobes
module prv_trap_ctrl
  import machine_mode_types_1_12_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env,
  input  logic        mal_l,
  input  logic        mal_s,
  input  logic        fault_l,
  input  logic        fault_s,
  input  logic        ret,
  input  logic        wfi,
  input  logic        pipe_clear,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic [2:0]  mie_bits,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_r,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        intr,
  output logic        wfi_stall,
  output logic        mcause_we,
  output logic        mepc_we,
  output logic        mtval_we,
  output logic [31:0] mcause_wdata,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mtval_wdata,
  output logic        mstatus_trap,
  output logic        mstatus_ret
);

  trap_state_t r_state, w_state_nxt;
  logic        r_is_trap, w_is_trap_nxt;
  logic [31:0] r_cause, w_cause_nxt;
  logic [31:0] r_epc, w_epc_nxt;
  logic [31:0] r_tval, w_tval_nxt;
  logic [31:0] r_target, w_target_nxt;

  logic [2:0]  w_pend;
  logic        w_exc_valid, w_exc_tval, w_int_valid, w_int_req, w_redir;
  exc_code_t   w_exc_code;
  int_code_t   w_int_code;
  logic [31:0] w_base, w_int_target;

  assign w_pend = {ext_int, soft_int, timer_int} & mie_bits;
  assign w_base = {mtvec[31:2], 2'b00};

  prv_trap_prio_enc u_prio (
    .i_fault_insn   (fault_insn),
    .i_mal_insn     (mal_insn),
    .i_illegal_insn (illegal_insn),
    .i_breakpoint   (breakpoint),
    .i_env          (env),
    .i_mal_l        (mal_l),
    .i_mal_s        (mal_s),
    .i_fault_l      (fault_l),
    .i_fault_s      (fault_s),
    .i_pend         (w_pend),
    .o_exc_valid    (w_exc_valid),
    .o_exc_code     (w_exc_code),
    .o_exc_tval     (w_exc_tval),
    .o_int_valid    (w_int_valid),
    .o_int_code     (w_int_code)
  );

`ifdef PRV_TRAP_VECTORED_EN
  assign w_int_target = (mtvec[1:0] == 2'b01) ? (w_base + {26'd0, w_int_code, 2'b00}) : w_base;
`else
  logic w_unused_mtvec_mode;
  assign w_unused_mtvec_mode = ^mtvec[1:0];
  assign w_int_target = w_base;
`endif

  assign w_int_req = (r_state == IDLE) && w_int_valid && mstatus_mie;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_is_trap <= 1'b0;
      r_cause   <= '0;
      r_epc     <= '0;
      r_tval    <= '0;
      r_target  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_is_trap <= w_is_trap_nxt;
      r_cause   <= w_cause_nxt;
      r_epc     <= w_epc_nxt;
      r_tval    <= w_tval_nxt;
      r_target  <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_is_trap_nxt = r_is_trap;
    w_cause_nxt   = r_cause;
    w_epc_nxt     = r_epc;
    w_tval_nxt    = r_tval;
    w_target_nxt  = r_target;
    case (r_state)
      IDLE: begin
        if (w_exc_valid) begin
          w_state_nxt   = REDIRECT;
          w_is_trap_nxt = 1'b1;
          w_cause_nxt   = mk_cause(1'b0, w_exc_code);
          w_epc_nxt     = epc;
          w_tval_nxt    = w_exc_tval ? badaddr : 32'd0;
          w_target_nxt  = w_base;
        end else if (w_int_req && pipe_clear) begin
          w_state_nxt   = REDIRECT;
          w_is_trap_nxt = 1'b1;
          w_cause_nxt   = mk_cause(1'b1, w_int_code);
          w_epc_nxt     = epc;
          w_tval_nxt    = 32'd0;
          w_target_nxt  = w_int_target;
        end else if (ret) begin
          w_state_nxt   = REDIRECT;
          w_is_trap_nxt = 1'b0;
          w_cause_nxt   = 32'd0;
          w_epc_nxt     = 32'd0;
          w_tval_nxt    = 32'd0;
          w_target_nxt  = mepc_r;
        end else if (wfi) begin
          w_state_nxt = WFI_WAIT;
        end
      end
      // wake on any enabled pending interrupt, even with global MIE clear
      WFI_WAIT: if (|w_pend) w_state_nxt = IDLE;
      REDIRECT: w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign w_redir      = (r_state == REDIRECT);
  assign insert_pc    = w_redir;
  assign priv_pc      = w_redir ? r_target : 32'd0;
  assign intr         = w_int_req;
  assign wfi_stall    = (r_state == WFI_WAIT);
  assign mcause_we    = w_redir & r_is_trap;
  assign mepc_we      = w_redir & r_is_trap;
  assign mtval_we     = w_redir & r_is_trap;
  assign mstatus_trap = w_redir & r_is_trap;
  assign mstatus_ret  = w_redir & ~r_is_trap;
  assign mcause_wdata = mcause_we ? r_cause : 32'd0;
  assign mepc_wdata   = mepc_we ? r_epc : 32'd0;
  assign mtval_wdata  = mtval_we ? r_tval : 32'd0;

endmodule
